tmfir_sequencer: RTL

- Handshake front-end and back-end controller for the time-multiplexed N×M-tap FIR core.
- Accepts one input sample over a valid/ready stream and drives the core's start/EN sequencing for the M multiplexed cycles.
- Captures the accumulated core output into a one-entry output buffer, presented on a valid/ready stream.
- Sits between the sample source (ADC/deserializer) and the FIR core; a downstream consumer drains the results.

---
 rtl/tmfir_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/tmfir_sequencer.sv
// Valid/ready front-end and back-end controller for the time-multiplexed FIR core:
// one sample in, start/enable sequencing for M core cycles, one-entry result buffer out.
module tmfir_sequencer #(
  parameter int M    = 3,
  parameter int WIN  = 12,
  parameter int WOUT = 12,
  parameter int LML  = 4
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [WIN-1:0]  s_data,
  output logic            fir_start,
  output logic            fir_en,
  output logic [WIN-1:0]  fir_in,
  input  logic [WOUT-1:0] fir_out,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [WOUT-1:0] m_data,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;

  localparam logic [LML-1:0] PHASE_LAST = LML'(M - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [LML-1:0]         phase;
  logic [LML-1:0]         phase_nxt;
  logic signed [WIN-1:0]  sample_p0;
  logic                   accept;
  logic                   capture;
  logic                   drain;

  assign drain  = m_valid & m_ready;
  assign fir_in = sample_p0;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Core control decodes straight from the state, so an asynchronous reset
  // drops start/enable in the same instant it returns the FSM to IDLE.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    s_ready   = 1'b0;
    fir_start = 1'b0;
    fir_en    = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        accept  = s_valid;
        if (s_valid) state_nxt = LOAD;
      end
      LOAD: begin
        fir_start = 1'b1;
        phase_nxt = '0;
        state_nxt = RUN;
      end
      RUN: begin
        fir_en    = 1'b1;
        phase_nxt = phase + 1'b1;
        if (phase == PHASE_LAST) state_nxt = CAPT;
      end
      CAPT: begin
        // Enable stays low here, so the core keeps its accumulator while we stall.
        if (!m_valid || m_ready) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: sample register feeding the core ----
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sample_p0 <= '0;
    end else if (accept) begin
      sample_p0 <= s_data;
    end
  end

  // ---- output buffer: a capture in the drain cycle keeps m_valid high ----
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (capture) begin
      m_valid <= 1'b1;
      m_data  <= fir_out;
    end else if (drain) begin
      m_valid <= 1'b0;
    end
  end

endmodule
